// File: rtl/pkt_rx_reader.sv
// Drain engine for the 10GE MAC receive packet interface: reads frames word by word,
// forwards the stream one cycle later and reports per-frame length, status and counts.
module pkt_rx_reader #(
    parameter int unsigned MAX_LEN = 1518,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk_156m25,
    input  logic        reset_156m25,
    input  logic        enable,
    input  logic        pkt_rx_avail,
    output logic        pkt_rx_ren,
    input  logic        pkt_rx_val,
    input  logic [63:0] pkt_rx_data,
    input  logic        pkt_rx_sop,
    input  logic        pkt_rx_eop,
    input  logic [2:0]  pkt_rx_mod,
    input  logic        pkt_rx_err,
    output logic        out_val,
    output logic        out_sop,
    output logic        out_eop,
    output logic [63:0] out_data,
    output logic [2:0]  out_mod,
    output logic        frame_done,
    output logic [15:0] frame_len,
    output logic [4:0]  frame_status,
    output logic [31:0] frame_cnt,
    output logic [15:0] err_cnt
);

    localparam int unsigned DW = 64;
    localparam int unsigned LW = 16;
    localparam int unsigned SW = 5;
    localparam int unsigned CW = 32;
    localparam int unsigned EW = 16;
    localparam int unsigned IW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [LW-1:0]   len_q, len_d;
    logic [SW-1:0]   stat_q, stat_d;
    logic            sop_seen_q, sop_seen_d;
    logic            any_val_q, any_val_d;
    logic [IW-1:0]   idle_q, idle_d;

    logic            start;
    logic            last_word;
    logic            timeout_hit;
    logic            frame_end;
    logic [3:0]      add_bytes;
    logic [LW:0]     len_sum;
    logic [SW-1:0]   fin_status;

    logic            frame_done_q;
    logic [LW-1:0]   frame_len_q;
    logic [SW-1:0]   frame_status_q;
    logic [CW-1:0]   frame_cnt_q;
    logic [EW-1:0]   err_cnt_q;
    logic            out_val_q, out_sop_q, out_eop_q;
    logic [DW-1:0]   out_data_q;
    logic [2:0]      out_mod_q;

    assign start       = (state_q == S_IDLE) && enable && pkt_rx_avail;
    assign last_word   = (state_q == S_READ) && pkt_rx_val && pkt_rx_eop;
    assign timeout_hit = (state_q == S_READ) && !pkt_rx_val && (idle_q == IW'(TIMEOUT - 1));
    assign frame_end   = last_word || timeout_hit;

    // State register
    always_ff @(posedge clk_156m25 or posedge reset_156m25) begin
        if (reset_156m25) state_q <= S_IDLE;
        else              state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_READ;
            S_READ:  if (frame_end) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Read enable drops combinationally in the eop or timeout cycle
    always_comb begin
        pkt_rx_ren = (state_q == S_READ) && !(pkt_rx_val && pkt_rx_eop) && !timeout_hit;
    end

    // Per-frame accumulators
    always_comb begin
        len_d      = len_q;
        stat_d     = stat_q;
        sop_seen_d = sop_seen_q;
        any_val_d  = any_val_q;
        idle_d     = idle_q;
        add_bytes  = (pkt_rx_eop && (pkt_rx_mod != 3'd0)) ? {1'b0, pkt_rx_mod} : 4'd8;
        len_sum    = {1'b0, len_q} + (LW + 1)'(add_bytes);
        if (start) begin
            len_d      = '0;
            stat_d     = '0;
            sop_seen_d = 1'b0;
            any_val_d  = 1'b0;
            idle_d     = '0;
        end else if (state_q == S_READ) begin
            if (pkt_rx_val) begin
                len_d     = len_sum[LW] ? '1 : len_sum[LW-1:0];
                idle_d    = '0;
                any_val_d = 1'b1;
                if (pkt_rx_sop) begin
                    if (sop_seen_q) stat_d[2] = 1'b1;
                    sop_seen_d = 1'b1;
                end
                if (!any_val_q && !pkt_rx_sop) stat_d[1] = 1'b1;
                if (pkt_rx_eop && pkt_rx_err) stat_d[0] = 1'b1;
            end else begin
                idle_d = idle_q + IW'(1);
                if (timeout_hit) stat_d[4] = 1'b1;
            end
        end
        fin_status = stat_d | {1'b0, (len_d > LW'(MAX_LEN)), 3'b000};
    end

    always_ff @(posedge clk_156m25 or posedge reset_156m25) begin
        if (reset_156m25) begin
            len_q      <= '0;
            stat_q     <= '0;
            sop_seen_q <= 1'b0;
            any_val_q  <= 1'b0;
            idle_q     <= '0;
        end else begin
            len_q      <= len_d;
            stat_q     <= stat_d;
            sop_seen_q <= sop_seen_d;
            any_val_q  <= any_val_d;
            idle_q     <= idle_d;
        end
    end

    // Frame results land on the edge that enters DONE, so they coincide with frame_done
    always_ff @(posedge clk_156m25 or posedge reset_156m25) begin
        if (reset_156m25) begin
            frame_done_q   <= 1'b0;
            frame_len_q    <= '0;
            frame_status_q <= '0;
            frame_cnt_q    <= '0;
            err_cnt_q      <= '0;
        end else begin
            frame_done_q <= frame_end;
            if (frame_end) begin
                frame_len_q    <= len_d;
                frame_status_q <= fin_status;
                frame_cnt_q    <= frame_cnt_q + CW'(1);
                if ((fin_status != '0) && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + EW'(1);
            end
        end
    end

    // Unconditional one-cycle pass-through
    always_ff @(posedge clk_156m25 or posedge reset_156m25) begin
        if (reset_156m25) begin
            out_val_q  <= 1'b0;
            out_sop_q  <= 1'b0;
            out_eop_q  <= 1'b0;
            out_data_q <= '0;
            out_mod_q  <= '0;
        end else begin
            out_val_q  <= pkt_rx_val;
            out_sop_q  <= pkt_rx_sop;
            out_eop_q  <= pkt_rx_eop;
            out_data_q <= pkt_rx_data;
            out_mod_q  <= pkt_rx_mod;
        end
    end

    assign out_val      = out_val_q;
    assign out_sop      = out_sop_q;
    assign out_eop      = out_eop_q;
    assign out_data     = out_data_q;
    assign out_mod      = out_mod_q;
    assign frame_done   = frame_done_q;
    assign frame_len    = frame_len_q;
    assign frame_status = frame_status_q;
    assign frame_cnt    = frame_cnt_q;
    assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_pkt_rx_reader.sv
// Scoreboard bench for pkt_rx_reader: a small MAC model drives directed frames,
// expected words and frame results are queued and checked by a negedge monitor.
module tb_pkt_rx_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic        avail = 1'b0;
    logic        ren;
    logic        val = 1'b0;
    logic [63:0] data = '0;
    logic        sop = 1'b0, eop = 1'b0, err = 1'b0;
    logic [2:0]  mod = '0;
    logic        o_val, o_sop, o_eop;
    logic [63:0] o_data;
    logic [2:0]  o_mod;
    logic        done;
    logic [15:0] flen;
    logic [4:0]  fstat;
    logic [31:0] fcnt;
    logic [15:0] ecnt;

    typedef struct packed {
        logic [63:0] d;
        logic        s;
        logic        e;
        logic [2:0]  m;
    } word_t;

    typedef struct packed {
        logic [15:0] len;
        logic [4:0]  st;
        logic [31:0] cnt;
        logic [15:0] ec;
    } res_t;

    word_t word_q[$];
    res_t  res_q[$];
    int    checks = 0;
    int    errors = 0;
    int    fid = 0;

    always #5 clk = ~clk;

    pkt_rx_reader dut (
        .clk_156m25   (clk),
        .reset_156m25 (rst),
        .enable       (enable),
        .pkt_rx_avail (avail),
        .pkt_rx_ren   (ren),
        .pkt_rx_val   (val),
        .pkt_rx_data  (data),
        .pkt_rx_sop   (sop),
        .pkt_rx_eop   (eop),
        .pkt_rx_mod   (mod),
        .pkt_rx_err   (err),
        .out_val      (o_val),
        .out_sop      (o_sop),
        .out_eop      (o_eop),
        .out_data     (o_data),
        .out_mod      (o_mod),
        .frame_done   (done),
        .frame_len    (flen),
        .frame_status (fstat),
        .frame_cnt    (fcnt),
        .err_cnt      (ecnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic expect_frame(input int len, input int st, input int cnt, input int ec);
        res_t r;
        r.len = 16'(len);
        r.st  = 5'(st);
        r.cnt = 32'(cnt);
        r.ec  = 16'(ec);
        res_q.push_back(r);
    endtask

    // Monitor: pass-through words and frame results
    always @(negedge clk) begin
        if (o_val) begin
            if (word_q.size() == 0) chk("unexpected_out_val", 64'(o_val), 64'd0);
            else begin
                word_t w;
                w = word_q.pop_front();
                chk("out_data", o_data, w.d);
                chk("out_flags", 64'({o_sop, o_eop, o_mod}), 64'({w.s, w.e, w.m}));
            end
        end
        if (done) begin
            if (res_q.size() == 0) chk("unexpected_frame_done", 64'(done), 64'd0);
            else begin
                res_t r;
                r = res_q.pop_front();
                chk("frame_len", 64'(flen), 64'(r.len));
                chk("frame_status", 64'(fstat), 64'(r.st));
                chk("frame_cnt", 64'(fcnt), 64'(r.cnt));
                chk("err_cnt", 64'(ecnt), 64'(r.ec));
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_ren"}, 64'(ren), 64'd0);
        chk({tag, "_outs"}, 64'({o_val, o_sop, o_eop, o_mod}), 64'd0);
        chk({tag, "_out_data"}, o_data, 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_len_stat"}, 64'({flen, fstat}), 64'd0);
        chk({tag, "_counts"}, 64'({fcnt, ecnt}), 64'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        val = 1'b0; sop = 1'b0; eop = 1'b0; err = 1'b0; avail = 1'b0;
        #1;
        word_q.delete();
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // MAC model: one-cycle read latency; stop_after>0 abandons the frame after that many words
    task automatic send_frame(input int nw, input logic [2:0] m, input logic e,
                              input logic with_sop, input int dup, input int stop_after);
        int    i;
        int    cyc;
        logic  rs;
        word_t w;
        fid++;
        @(posedge clk);
        #1 avail = 1'b1;
        @(negedge clk);
        chk("ren_before_start", 64'(ren), 64'd0);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!ren && cyc < 8);
        chk("ren_rise_latency", 64'(cyc), 64'd1);
        if (!ren) begin
            avail = 1'b0;
            return;
        end
        i = 0;
        cyc = 0;
        while (i < nw && cyc < nw + 20) begin
            rs = ren;
            cyc++;
            @(posedge clk);
            #1 avail = 1'b0;
            if (rs) begin
                w.d = {32'hC0DE0000 | 32'(fid), 32'(i)};
                w.s = (with_sop && i == 0) || (i == dup);
                w.e = (i == nw - 1);
                w.m = w.e ? m : 3'd0;
                val = 1'b1; data = w.d; sop = w.s; eop = w.e; mod = w.m;
                err = w.e && e;
                word_q.push_back(w);
                i++;
            end else begin
                val = 1'b0; sop = 1'b0; eop = 1'b0; err = 1'b0; mod = '0;
            end
            if (stop_after > 0 && i == stop_after) return;
            @(negedge clk);
            if (i == nw && rs) chk("ren_low_in_eop", 64'(ren), 64'd0);
        end
        chk("words_sent", 64'(i), 64'(nw));
        @(posedge clk);
        #1 val = 1'b0; sop = 1'b0; eop = 1'b0; err = 1'b0; mod = '0;
        @(negedge clk);
        chk("done_after_eop", 64'(done), 64'd1);
    endtask

    initial begin
        int cnt;
        #2;
        check_all_zero("initial_reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // enable low blocks a new frame
        enable = 1'b0;
        avail  = 1'b1;
        repeat (3) @(negedge clk);
        chk("ren_with_enable_low", 64'(ren), 64'd0);
        @(posedge clk);
        #1 avail = 1'b0; enable = 1'b1;

        // 64-byte then 61-byte frame
        expect_frame(64, 0, 1, 0);
        send_frame(8, 3'd0, 1'b0, 1'b1, -1, 0);
        expect_frame(61, 0, 2, 0);
        send_frame(8, 3'd5, 1'b0, 1'b1, -1, 0);

        // MAC error then clean frame
        do_reset();
        expect_frame(64, 5'b00001, 1, 1);
        send_frame(8, 3'd0, 1'b1, 1'b1, -1, 0);
        expect_frame(64, 0, 2, 1);
        send_frame(8, 3'd0, 1'b0, 1'b1, -1, 0);

        // Timeout: avail but the MAC never returns data
        do_reset();
        expect_frame(0, 5'b10000, 1, 1);
        @(posedge clk);
        #1 avail = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("timeout_ren_rise", 64'(ren), 64'd1);
        cnt = 0;
        while (ren && cnt < 40) begin
            cnt++;
            @(posedge clk);
            #1 avail = 1'b0;
            @(negedge clk);
        end
        chk("timeout_ren_cycles", 64'(cnt), 64'd15);
        @(negedge clk);
        chk("timeout_done", 64'(done), 64'd1);

        // Missing sop, then oversize frame with a duplicate sop
        expect_frame(64, 5'b00010, 2, 2);
        send_frame(8, 3'd0, 1'b0, 1'b0, -1, 0);
        expect_frame(1528, 5'b01100, 3, 3);
        send_frame(191, 3'd0, 1'b0, 1'b1, 100, 0);

        // Reset mid-frame, then a fresh frame counts from zero
        send_frame(8, 3'd0, 1'b0, 1'b1, -1, 3);
        do_reset();
        expect_frame(64, 0, 1, 0);
        send_frame(8, 3'd0, 1'b0, 1'b1, -1, 0);

        repeat (4) @(negedge clk);
        chk("word_queue_empty", 64'(word_q.size()), 64'd0);
        chk("result_queue_empty", 64'(res_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pkt_rx_reader.md
# pkt_rx_reader

Synthesizable drain engine for the 10GE MAC receive packet interface, running in the 156.25 MHz domain. It waits for a frame to become available, asserts the read enable, consumes 64-bit words until end-of-packet, and forwards the stream one cycle later. For each frame it computes the byte length, framing and error status, and keeps frame and error counters, so scoreboards and self-checking benches read hardware counts instead of counting in software.

## Interface
- MAX_LEN, 1518: largest legal frame in bytes; anything longer is flagged oversize.
- TIMEOUT, 16: consecutive READ cycles without pkt_rx_val before the frame is aborted.
- clk_156m25  in  1  clock, rising edge.
- reset_156m25  in  1  reset, asynchronous, active-high.
- enable  in  1  permits starting a new frame; sampled only in IDLE.
- pkt_rx_avail  in  1  MAC has a frame queued.
- pkt_rx_ren  out  1  read enable to MAC.
- pkt_rx_val  in  1  data word valid; 1-cycle read latency after ren.
- pkt_rx_data  in  64  data word.
- pkt_rx_sop, pkt_rx_eop  in  1 each  frame start and end markers, qualified by val.
- pkt_rx_mod  in  3  valid bytes on the eop word; 0 means 8.
- pkt_rx_err  in  1  MAC error flag, qualified by val&eop.
- out_val, out_sop, out_eop  out  1 each  registered copies of the input stream.
- out_data  out  64  registered copy of the input stream.
- out_mod  out  3  registered copy of the input stream.
- frame_done  out  1  one-cycle pulse at frame end.
- frame_len  out  16  byte length of the last frame.
- frame_status  out  5  [0] rx_err, [1] missing sop, [2] duplicate sop, [3] oversize, [4] timeout.
- frame_cnt  out  32  frames completed; wraps.
- err_cnt  out  16  frames with nonzero status; saturates at 16'hFFFF.

## Operation
- States: IDLE, READ, DONE.
- IDLE → READ when enable && pkt_rx_avail. The length accumulator, status bits, sop_seen flag and idle counter clear on this transition.
- READ, ren: pkt_rx_ren = (state==READ) && !(pkt_rx_val && pkt_rx_eop) && !timeout_hit. It is combinational, so ren drops in the eop cycle itself.
- READ, per val word:
  - Non-eop word adds 8 to the length.
  - Eop word adds (mod==0 ? 8 : mod).
  - Length saturates at 16'hFFFF.
- READ, status flags:
  - val&sop with sop_seen set → bit2.
  - First val word without sop → bit1.
  - val&eop&pkt_rx_err → bit0.
- READ, idle counter: increments on each cycle without val and resets on val. Reaching TIMEOUT sets bit4 and forces exit.
- READ → DONE on val&eop or on timeout.
- DONE:
  - Registers frame_len and frame_status; sets bit3 if len > MAX_LEN.
  - Pulses frame_done.
  - Increments frame_cnt, and increments err_cnt if status ≠ 0.
  - Returns to IDLE.
- Deasserting enable mid-frame has no effect; the frame completes.
- Pass-through: out_* = pkt_rx_* delayed one cycle. It is unconditional and includes words outside READ.

## Timing
- Reset: state IDLE. pkt_rx_ren, out_* , frame_done, frame_len, frame_status, frame_cnt and err_cnt are all 0, effective immediately on assertion, including mid-frame. A partially read frame is discarded and not counted.
- ren rises 1 cycle after the IDLE edge where avail&enable are sampled. The first val appears 1 cycle after that.
- frame_done is high exactly 1 cycle, the cycle after the eop word or timeout cycle. frame_len, frame_status and the counters are valid in that same cycle and held until the next frame_done.
- Minimum spacing between frames is 3 cycles from eop to the next ren: DONE, IDLE, ren.
- Pass-through latency is 1 cycle, with no backpressure.

## Test plan
- 64-byte frame (8 words, sop on word 0, eop on word 7, mod=0) → frame_len=64, status=0, frame_cnt=1, err_cnt=0. frame_done 1 cycle after the eop word; ren low in the eop cycle.
- 61-byte frame (8 words, mod=5) → frame_len=61, status=0. out_* matches the input words delayed 1 cycle.
- Frame with pkt_rx_err on eop, then a clean frame → status 5'b00001 then 0. err_cnt=1, frame_cnt=2.
- avail, then no val for 16 cycles (TIMEOUT=16) → ren drops, frame_done with status bit4, frame_len=0, err_cnt=1.
- 191 words, mod=0 (1528 bytes, MAX_LEN=1518) → status bit3; second sop injected mid-frame → bit2 also set.
- Assert reset after the 3rd word of a frame → ren and all outputs 0 immediately. After release, a fresh 64-byte frame yields frame_cnt=1, frame_len=64.
